// File: rtl/sd_spi_cmd_seq.sv
// SD-card SPI-mode command sequencer: power-up clocking, 6-byte command frames,
// R1 polling and optional single-block reads over a byte-wide SPI engine.
// Optional build macro SD_CRC7_EN computes the real CRC7 for every command frame.
module sd_spi_cmd_seq #(
    parameter int RESP_TRIES  = 8,
    parameter int TOKEN_TRIES = 4096,
    parameter int BLOCK_LEN   = 512,
    parameter int INIT_BYTES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        init_start,
    input  logic        cmd_start,
    input  logic [5:0]  cmd_idx,
    input  logic [31:0] cmd_arg,
    input  logic        cmd_rd,
    output logic        busy,
    output logic        done,
    output logic [7:0]  r1,
    output logic        err_resp,
    output logic        err_token,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        cs_n,
    output logic [7:0]  spi_di,
    output logic        spi_wr,
    input  logic [7:0]  spi_do,
    input  logic        spi_dsr
);
    localparam int DW = $clog2(BLOCK_LEN) + 1;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_INIT  = 4'd1;
    localparam logic [3:0] S_CMD   = 4'd2;
    localparam logic [3:0] S_RESP  = 4'd3;
    localparam logic [3:0] S_TOKEN = 4'd4;
    localparam logic [3:0] S_DATA  = 4'd5;
    localparam logic [3:0] S_CRC   = 4'd6;
    localparam logic [3:0] S_TRAIL = 4'd7;
    localparam logic [3:0] S_FIN   = 4'd8;

    localparam logic [1:0] B_IDLE = 2'd0;
    localparam logic [1:0] B_REQ  = 2'd1;
    localparam logic [1:0] B_BUSY = 2'd2;
    localparam logic [1:0] B_GAP  = 2'd3;

    localparam logic [12:0]   INIT_LAST  = 13'(INIT_BYTES - 1);
    localparam logic [12:0]   RESP_LAST  = 13'(RESP_TRIES - 1);
    localparam logic [12:0]   TOKEN_LAST = 13'(TOKEN_TRIES - 1);
    localparam logic [DW-1:0] DATA_LAST  = DW'(BLOCK_LEN - 1);

    logic [3:0]    state_r;
    logic [1:0]    b_state_r;
    logic [12:0]   cnt_r;
    logic [DW-1:0] dcnt_r;
    logic [7:0]    tx_r;
    logic [7:0]    rx_r;
    logic          byte_go_r;
    logic          byte_done_r;
    logic          armed_r;
    logic [5:0]    idx_r;
    logic [31:0]   arg_r;
    logic          rd_r;
    logic          capture_s;
    logic [7:0]    crc_byte_s;

`ifdef SD_CRC7_EN
    function automatic logic [6:0] crc7_calc(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c  = {c[5:0], 1'b0};
            if (fb) begin
                c = c ^ 7'h09;
            end else begin
                c = c;
            end
        end
        return c;
    endfunction

    assign crc_byte_s = {crc7_calc({2'b01, idx_r, arg_r}), 1'b1};
`else
    // Fixed CRC bytes cover the only commands sent before CRC checking is off.
    function automatic logic [7:0] crc_fixed(input logic [5:0] idx);
        case (idx)
            6'd0:    return 8'h95;
            6'd8:    return 8'h87;
            default: return 8'h01;
        endcase
    endfunction

    assign crc_byte_s = crc_fixed(idx_r);
`endif

    function automatic logic [7:0] hdr_byte(input logic [2:0] k, input logic [31:0] arg,
                                            input logic [7:0] crc);
        case (k)
            3'd1:    return arg[31:24];
            3'd2:    return arg[23:16];
            3'd3:    return arg[15:8];
            3'd4:    return arg[7:0];
            3'd5:    return crc;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [12:0] sat_inc(input logic [12:0] v);
        return (v == 13'h1FFF) ? v : v + 13'd1;
    endfunction

    assign capture_s = (b_state_r == B_BUSY) && armed_r && spi_dsr;

    // Byte handshake: request, wait for a fresh dsr, then idle through one ce cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            b_state_r   <= B_IDLE;
            spi_wr      <= 1'b0;
            spi_di      <= 8'hFF;
            rx_r        <= 8'hFF;
            armed_r     <= 1'b0;
            byte_done_r <= 1'b0;
        end else begin
            byte_done_r <= 1'b0;
            case (b_state_r)
                B_IDLE: begin
                    if (byte_go_r) begin
                        b_state_r <= B_REQ;
                    end
                end
                B_REQ: begin
                    spi_di    <= tx_r;
                    spi_wr    <= 1'b1;
                    armed_r   <= 1'b0;
                    b_state_r <= B_BUSY;
                end
                B_BUSY: begin
                    if (capture_s) begin
                        spi_wr    <= 1'b0;
                        rx_r      <= spi_do;
                        b_state_r <= B_GAP;
                    end else if (!spi_dsr || ce) begin
                        armed_r <= 1'b1;
                    end
                end
                B_GAP: begin
                    if (ce) begin
                        byte_done_r <= 1'b1;
                        b_state_r   <= B_IDLE;
                    end
                end
                default: begin
                    spi_wr    <= 1'b0;
                    b_state_r <= B_IDLE;
                end
            endcase
        end
    end

    // Sequence control: start arbitration, framing, polling and block capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= S_IDLE;
            cnt_r     <= 13'd0;
            dcnt_r    <= '0;
            tx_r      <= 8'hFF;
            byte_go_r <= 1'b0;
            idx_r     <= 6'd0;
            arg_r     <= 32'd0;
            rd_r      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            r1        <= 8'hFF;
            err_resp  <= 1'b0;
            err_token <= 1'b0;
            rd_data   <= 8'd0;
            rd_valid  <= 1'b0;
            cs_n      <= 1'b1;
        end else begin
            byte_go_r <= 1'b0;
            done      <= 1'b0;
            rd_valid  <= 1'b0;
            if (capture_s && (state_r == S_DATA)) begin
                rd_valid <= 1'b1;
                rd_data  <= spi_do;
            end
            case (state_r)
                S_IDLE, S_FIN: begin
                    // FIN is the done cycle; a start arriving there is taken directly.
                    state_r <= S_IDLE;
                    if (init_start) begin
                        state_r   <= S_INIT;
                        busy      <= 1'b1;
                        err_resp  <= 1'b0;
                        err_token <= 1'b0;
                        cs_n      <= 1'b1;
                        cnt_r     <= 13'd0;
                        tx_r      <= 8'hFF;
                        byte_go_r <= 1'b1;
                    end else if (cmd_start) begin
                        state_r   <= S_CMD;
                        busy      <= 1'b1;
                        err_resp  <= 1'b0;
                        err_token <= 1'b0;
                        cs_n      <= 1'b0;
                        idx_r     <= cmd_idx;
                        arg_r     <= cmd_arg;
                        rd_r      <= cmd_rd;
                        cnt_r     <= 13'd0;
                        tx_r      <= {2'b01, cmd_idx};
                        byte_go_r <= 1'b1;
                    end
                end
                S_INIT: begin
                    if (byte_done_r) begin
                        if (cnt_r >= INIT_LAST) begin
                            state_r <= S_FIN;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            cnt_r     <= sat_inc(cnt_r);
                            byte_go_r <= 1'b1;
                        end
                    end
                end
                S_CMD: begin
                    if (byte_done_r) begin
                        byte_go_r <= 1'b1;
                        if (cnt_r >= 13'd5) begin
                            state_r <= S_RESP;
                            cnt_r   <= 13'd0;
                            tx_r    <= 8'hFF;
                        end else begin
                            cnt_r <= sat_inc(cnt_r);
                            tx_r  <= hdr_byte(cnt_r[2:0] + 3'd1, arg_r, crc_byte_s);
                        end
                    end
                end
                S_RESP: begin
                    if (byte_done_r) begin
                        byte_go_r <= 1'b1;
                        tx_r      <= 8'hFF;
                        if (!rx_r[7]) begin
                            r1 <= rx_r;
                            if (rd_r && (rx_r == 8'h00)) begin
                                state_r <= S_TOKEN;
                                cnt_r   <= 13'd0;
                            end else begin
                                state_r <= S_TRAIL;
                                cs_n    <= 1'b1;
                            end
                        end else if (cnt_r >= RESP_LAST) begin
                            err_resp <= 1'b1;
                            r1       <= 8'hFF;
                            state_r  <= S_TRAIL;
                            cs_n     <= 1'b1;
                        end else begin
                            cnt_r <= sat_inc(cnt_r);
                        end
                    end
                end
                S_TOKEN: begin
                    if (byte_done_r) begin
                        byte_go_r <= 1'b1;
                        tx_r      <= 8'hFF;
                        if (rx_r == 8'hFE) begin
                            state_r <= S_DATA;
                            dcnt_r  <= '0;
                        end else if ((rx_r[7:4] == 4'b0000) || (cnt_r >= TOKEN_LAST)) begin
                            err_token <= 1'b1;
                            state_r   <= S_TRAIL;
                            cs_n      <= 1'b1;
                        end else begin
                            cnt_r <= sat_inc(cnt_r);
                        end
                    end
                end
                S_DATA: begin
                    if (byte_done_r) begin
                        byte_go_r <= 1'b1;
                        tx_r      <= 8'hFF;
                        if (dcnt_r >= DATA_LAST) begin
                            state_r <= S_CRC;
                            cnt_r   <= 13'd0;
                        end else begin
                            dcnt_r <= dcnt_r + DW'(1);
                        end
                    end
                end
                S_CRC: begin
                    if (byte_done_r) begin
                        byte_go_r <= 1'b1;
                        tx_r      <= 8'hFF;
                        if (cnt_r >= 13'd1) begin
                            state_r <= S_TRAIL;
                            cs_n    <= 1'b1;
                        end else begin
                            cnt_r <= sat_inc(cnt_r);
                        end
                    end
                end
                S_TRAIL: begin
                    if (byte_done_r) begin
                        state_r <= S_FIN;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy    <= 1'b0;
                    cs_n    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sd_spi_cmd_seq.sv
// Directed bench for sd_spi_cmd_seq with a behavioural SPI engine and scripted card replies.
module tb_sd_spi_cmd_seq;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce = 1'b1;
    logic        init_start, cmd_start, cmd_rd;
    logic [5:0]  cmd_idx;
    logic [31:0] cmd_arg;
    logic        busy, done, err_resp, err_token, rd_valid, cs_n, spi_wr, spi_dsr;
    logic [7:0]  r1, rd_data, spi_di, spi_do;

    int n_checks = 0;
    int n_fail   = 0;
    int gap_viol = 0;
    logic gap_ce  = 1'b1;
    logic wr_prev = 1'b0;
    logic slow    = 1'b0;
    logic [1:0] ce_cnt = 2'd0;

    logic [1:0] eng_st;
    logic [7:0] eng_miso;
    logic [7:0] miso_q[$];
    logic [8:0] mosi_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] exp_q[$];

    sd_spi_cmd_seq dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .init_start(init_start), .cmd_start(cmd_start),
        .cmd_idx(cmd_idx), .cmd_arg(cmd_arg), .cmd_rd(cmd_rd), .busy(busy), .done(done),
        .r1(r1), .err_resp(err_resp), .err_token(err_token), .rd_data(rd_data),
        .rd_valid(rd_valid), .cs_n(cs_n), .spi_di(spi_di), .spi_wr(spi_wr),
        .spi_do(spi_do), .spi_dsr(spi_dsr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        ce_cnt <= ce_cnt + 2'd1;
        ce     <= slow ? (ce_cnt == 2'd0) : 1'b1;
    end

    // Engine model: accept on a ce cycle, answer one ce later, rest until wr is seen low.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eng_st  <= 2'd0;
            spi_dsr <= 1'b0;
            spi_do  <= 8'hFF;
        end else if (ce) begin
            case (eng_st)
                2'd0: if (spi_wr) begin
                    spi_dsr <= 1'b0;
                    mosi_q.push_back({cs_n, spi_di});
                    eng_miso <= (miso_q.size() > 0) ? miso_q.pop_front() : 8'hFF;
                    eng_st <= 2'd1;
                end
                2'd1: begin
                    spi_do  <= eng_miso;
                    spi_dsr <= 1'b1;
                    eng_st  <= 2'd2;
                end
                default: if (!spi_wr) eng_st <= 2'd0;
            endcase
        end
    end

    always @(posedge clk) begin
        wr_prev <= spi_wr;
        if (spi_wr && !wr_prev) begin
            if (!gap_ce) gap_viol <= gap_viol + 1;
            gap_ce <= 1'b0;
        end else if (!spi_wr && ce) begin
            gap_ce <= 1'b1;
        end
    end

    always @(negedge clk) if (rd_valid) rd_q.push_back(rd_data);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_done"}, {31'd0, got}, 32'd1);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic start_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                             input logic rd);
        mosi_q.delete();
        rd_q.delete();
        @(negedge clk);
        cmd_idx = idx; cmd_arg = arg; cmd_rd = rd; cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        chk({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
        chk({tag, "_err_clear"}, {30'd0, err_resp, err_token}, 32'd0);
    endtask

    task automatic cmp_mosi(input string tag);
        logic [31:0] obs;
        chk({tag, "_nbytes"}, mosi_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = (i < mosi_q.size()) ? {24'd0, mosi_q[i][7:0]} : 32'hDEAD;
            chk($sformatf("%s_mosi%0d", tag, i), obs, {24'd0, exp_q[i]});
        end
    endtask

    initial begin
        int bad;
        reset_n = 1'b0; init_start = 1'b0; cmd_start = 1'b0; cmd_rd = 1'b0;
        cmd_idx = 6'd0; cmd_arg = 32'd0;
        #12;
        chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
        chk("rst_spi_wr", {31'd0, spi_wr}, 32'd0);
        chk("rst_spi_di", {24'd0, spi_di}, 32'hFF);
        chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
        chk("rst_r1", {24'd0, r1}, 32'hFF);
        chk("rst_errs", {30'd0, err_resp, err_token}, 32'd0);
        chk("rst_rd", {23'd0, rd_valid, rd_data}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Init: ten FF bytes with chip select high
        mosi_q.delete();
        @(negedge clk);
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        chk("init_busy_rise", {31'd0, busy}, 32'd1);
        wait_done("init", 2000);
        exp_q = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        cmp_mosi("init");
        bad = 0;
        foreach (mosi_q[i]) if (!mosi_q[i][8]) bad++;
        chk("init_cs_high", bad, 0);
        @(negedge clk);
        chk("init_busy_after", {31'd0, busy}, 32'd0);

        // CMD0, card answers 01 on the second poll
        miso_q = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
        start_cmd("cmd0", 6'd0, 32'd0, 1'b0);
        wait_done("cmd0", 2000);
        exp_q = {8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF, 8'hFF, 8'hFF};
        cmp_mosi("cmd0");
        chk("cmd0_r1", {24'd0, r1}, 32'h01);
        chk("cmd0_err", {30'd0, err_resp, err_token}, 32'd0);
        chk("cmd0_cs_frame", (mosi_q.size() > 7) ? {31'd0, mosi_q[7][8]} : 32'hDEAD, 32'd0);
        chk("cmd0_cs_trail", (mosi_q.size() > 8) ? {31'd0, mosi_q[8][8]} : 32'hDEAD, 32'd1);
        chk("cmd0_cs_idle", {31'd0, cs_n}, 32'd1);

        // CMD17 block read: r1=00, token after 3 polls, data i[7:0], 2 CRC bytes
        miso_q = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFE};
        for (int i = 0; i < 512; i++) miso_q.push_back(8'(i));
        miso_q.push_back(8'hAA);
        miso_q.push_back(8'h55);
        start_cmd("cmd17", 6'd17, 32'h0000_0200, 1'b1);
        wait_done("cmd17", 20000);
        chk("cmd17_nbytes", mosi_q.size(), 525);
        chk("cmd17_hdr0", (mosi_q.size() > 0) ? {24'd0, mosi_q[0][7:0]} : 32'hDEAD, 32'h51);
        chk("cmd17_arg1", (mosi_q.size() > 3) ? {24'd0, mosi_q[3][7:0]} : 32'hDEAD, 32'h02);
`ifndef SD_CRC7_EN
        chk("cmd17_crc", (mosi_q.size() > 5) ? {24'd0, mosi_q[5][7:0]} : 32'hDEAD, 32'h01);
`endif
        chk("cmd17_r1", {24'd0, r1}, 32'h00);
        chk("cmd17_err", {30'd0, err_resp, err_token}, 32'd0);
        chk("cmd17_nvalid", rd_q.size(), 512);
        bad = 0;
        foreach (rd_q[i]) if (rd_q[i] !== 8'(i)) bad++;
        chk("cmd17_data", bad, 0);
        chk("cmd17_cs_trail", (mosi_q.size() > 524) ? {31'd0, mosi_q[524][8]} : 32'hDEAD, 32'd1);

        // CMD8, card silent: exactly 8 polls then timeout
        miso_q.delete();
        start_cmd("cmd8", 6'd8, 32'h0000_01AA, 1'b0);
        wait_done("cmd8", 4000);
        exp_q = {8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87,
                 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        cmp_mosi("cmd8");
        chk("cmd8_err_resp", {31'd0, err_resp}, 32'd1);
        chk("cmd8_r1", {24'd0, r1}, 32'hFF);

        // CMD17 with error token 05 after r1=00
        miso_q = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h05};
        start_cmd("etok", 6'd17, 32'd0, 1'b1);
        wait_done("etok", 4000);
        chk("etok_nbytes", mosi_q.size(), 9);
        chk("etok_err", {30'd0, err_resp, err_token}, 32'd1);
        chk("etok_nvalid", rd_q.size(), 0);
        chk("etok_cs_n", {31'd0, cs_n}, 32'd1);

        // ce 1-in-4 with a second start while busy
        slow = 1'b1;
        miso_q = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
        gap_viol = 0;
        start_cmd("slow", 6'd0, 32'd0, 1'b0);
        repeat (20) @(negedge clk);
        cmd_idx = 6'd17; cmd_arg = 32'hFFFF_FFFF; cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        wait_done("slow", 4000);
        exp_q = {8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF, 8'hFF};
        cmp_mosi("slow");
        chk("slow_r1", {24'd0, r1}, 32'h01);
        repeat (60) @(negedge clk);
        chk("slow_no_restart", {31'd0, busy}, 32'd0);
        chk("slow_nbytes_after", mosi_q.size(), 8);
        chk("slow_gap", gap_viol, 0);
        slow = 1'b0;

        // init_start wins over a simultaneous cmd_start
        mosi_q.delete();
        @(negedge clk);
        init_start = 1'b1; cmd_start = 1'b1; cmd_idx = 6'd0;
        @(negedge clk);
        init_start = 1'b0; cmd_start = 1'b0;
        wait_done("both", 2000);
        chk("both_nbytes", mosi_q.size(), 10);
        chk("both_first", (mosi_q.size() > 0) ? {23'd0, mosi_q[0]} : 32'hDEAD, 32'h1FF);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
